// File: rtl/unidade_controle_param.sv
// Multi-cycle control unit (FETCH/DECODE/EXEC/WB, >=4 cycles per instruction); stalls in FETCH while IVALID=0.
// UC_ILLEGAL_TRAP_EN: opcodes 0x19-0x1E halt the core with ILLEGAL set instead of running as NOP.
module unidade_controle_param #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int NREG   = 16,
  localparam int RSEL_W = $clog2(NREG),
  localparam int IW     = 5 + 3*RSEL_W
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              IREQ,
  input  logic              IVALID,
  input  logic [IW-1:0]     C,
  output logic [PC_W-1:0]   PC,
  input  logic [5:0]        FLG,
  output logic [DATA_W-1:0] CTE,
  output logic              LOAD,
  output logic              CLRREG,
  output logic [RSEL_W-1:0] SRD,
  output logic [RSEL_W-1:0] SBA,
  output logic [RSEL_W-1:0] SBB,
  output logic [3:0]        SULA,
  output logic [1:0]        S,
  output logic              HALTED,
  output logic              ILLEGAL
);

  localparam int IMM_W = 2*RSEL_W;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [5:0]        flg_q, flg_d;
  logic              clr_q, clr_d;

  logic [4:0]        op;
  logic              op_alu, op_ldi, op_in, op_br, op_jmp, op_halt;
  logic              writes_rf, br_taken;
  logic [DATA_W-1:0] cte;
  logic [PC_W-1:0]   pc_inc;

  assign op        = ir_q[IW-1 -: 5];
  assign op_alu    = ~op[4];
  assign op_ldi    = (op == 5'h10);
  assign op_in     = (op == 5'h11);
  assign op_br     = (op >= 5'h12) && (op <= 5'h17);
  assign op_jmp    = (op == 5'h18);
  assign op_halt   = (op == 5'h1F);
  assign writes_rf = op_alu || op_ldi || op_in;
  assign cte       = DATA_W'(ir_q[IMM_W-1:0]);
  assign pc_inc    = pc_q + PC_W'(1);

  // Branch opcodes 0x12..0x17 select Z, L, LE, E, GE, G; FLG[5] is Z.
  always_comb begin
    br_taken = 1'b0;
    case (op[2:0])
      3'd2:    br_taken = flg_q[5];
      3'd3:    br_taken = flg_q[4];
      3'd4:    br_taken = flg_q[3];
      3'd5:    br_taken = flg_q[2];
      3'd6:    br_taken = flg_q[1];
      3'd7:    br_taken = flg_q[0];
      default: br_taken = 1'b0;
    endcase
  end

`ifdef UC_ILLEGAL_TRAP_EN
  logic ill_q, ill_d;
  logic op_bad;
  assign op_bad  = (op >= 5'h19) && (op <= 5'h1E);
  assign ILLEGAL = ill_q;
`else
  assign ILLEGAL = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flg_d   = flg_q;
    clr_d   = 1'b0;
`ifdef UC_ILLEGAL_TRAP_EN
    ill_d   = ill_q;
`endif
    case (state_q)
      ST_FETCH: begin
        // The register-file clear cycle after reset never accepts an instruction.
        if (!clr_q && IVALID) begin
          ir_d    = C;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
`ifdef UC_ILLEGAL_TRAP_EN
        if (op_bad) begin
          state_d = ST_HALT;
          ill_d   = 1'b1;
        end
`endif
      end
      ST_EXEC: begin
        flg_d   = FLG;
        state_d = ST_WB;
      end
      ST_WB: begin
        if (op_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          if (op_jmp || (op_br && br_taken)) pc_d = PC_W'(cte);
          else                               pc_d = pc_inc;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      flg_q   <= '0;
      clr_q   <= 1'b1;
`ifdef UC_ILLEGAL_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flg_q   <= flg_d;
      clr_q   <= clr_d;
`ifdef UC_ILLEGAL_TRAP_EN
      ill_q   <= ill_d;
`endif
    end
  end

  assign IREQ   = (state_q == ST_FETCH) && !clr_q;
  assign CLRREG = clr_q;
  assign LOAD   = (state_q == ST_WB) && writes_rf;
  assign HALTED = (state_q == ST_HALT);
  assign PC     = pc_q;
  assign CTE    = cte;
  assign SRD    = ir_q[3*RSEL_W-1 -: RSEL_W];
  assign SBA    = ir_q[2*RSEL_W-1 -: RSEL_W];
  assign SBB    = ir_q[RSEL_W-1:0];
  assign SULA   = op_alu ? op[3:0] : (op_br ? 4'b0111 : 4'b0000);
  assign S      = op_ldi ? 2'b01 : (op_in ? 2'b10 : 2'b00);

endmodule

// File: tb/tb_unidade_controle_param.sv
// Bench for unidade_controle_param: directed corner cases plus random instruction stream
// checked against an instruction-level model of PC, write-back and halt behaviour.
module tb_unidade_controle_param;
  localparam int DATA_W = 8;
  localparam int PC_W   = 8;
  localparam int NREG   = 16;
  localparam int RS     = 4;
  localparam int IW     = 17;
  localparam int PC_MOD = 1 << PC_W;

  logic              clk = 1'b0;
  logic              reset, ivalid;
  logic [IW-1:0]     c;
  logic [5:0]        flg;
  logic              ireq, load, clrreg, halted, illegal;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] cte;
  logic [RS-1:0]     srd, sba, sbb;
  logic [3:0]        sula;
  logic [1:0]        s;

  int checks = 0;
  int errors = 0;
  int mpc    = 0;

  always #5 clk = ~clk;

  unidade_controle_param #(.DATA_W(DATA_W), .PC_W(PC_W), .NREG(NREG)) dut (
    .CLK(clk), .RESET(reset), .IREQ(ireq), .IVALID(ivalid), .C(c), .PC(pc),
    .FLG(flg), .CTE(cte), .LOAD(load), .CLRREG(clrreg), .SRD(srd), .SBA(sba),
    .SBB(sbb), .SULA(sula), .S(s), .HALTED(halted), .ILLEGAL(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (ireq !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ireq !== 1'b1) chk("fetch_timeout", ireq, 1);
  endtask

  // Reset edge while optionally presenting a valid instruction; ends in the first fetch cycle.
  task automatic do_reset(input logic with_ivalid);
    reset  = 1'b1;
    ivalid = with_ivalid;
    c      = IW'($urandom);
    @(negedge clk);
    reset  = 1'b0;
    ivalid = 1'b0;
    chk("rst_clrreg", clrreg, 1);
    chk("rst_ireq", ireq, 0);
    chk("rst_pc", pc, 0);
    chk("rst_load", load, 0);
    chk("rst_sula", sula, 0);
    chk("rst_s", s, 0);
    chk("rst_srd", srd, 0);
    chk("rst_sba", sba, 0);
    chk("rst_sbb", sbb, 0);
    chk("rst_cte", cte, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk);
    chk("post_rst_clrreg", clrreg, 0);
    chk("post_rst_ireq", ireq, 1);
    chk("post_rst_load", load, 0);
    mpc = 0;
  endtask

  task automatic check_halted();
    for (int i = 0; i < 3; i++) begin
      ivalid = 1'b1;
      c      = IW'($urandom);
      @(negedge clk);
      ivalid = 1'b0;
      chk("halt_ireq", ireq, 0);
      chk("halt_halted", halted, 1);
      chk("halt_pc", pc, mpc);
      chk("halt_load", load, 0);
      @(negedge clk);
      chk("halt_ireq2", ireq, 0);
    end
  endtask

  task automatic do_instr(input int op, input int rd, input int imm, input logic [5:0] f);
    bit is_load, is_br, takes, trap;
    int exp_pc, exp_s;
    is_load = (op < 16) || (op == 16) || (op == 17);
    is_br   = (op >= 18) && (op <= 23);
    takes   = is_br && (((f >> (23 - op)) & 1) == 1);
    trap    = 1'b0;
`ifdef UC_ILLEGAL_TRAP_EN
    trap    = (op >= 25) && (op <= 30);
`endif
    exp_s   = (op == 16) ? 1 : (op == 17) ? 2 : 0;
    if (op == 24 || takes)      exp_pc = imm % PC_MOD;
    else if (op == 31 || trap)  exp_pc = mpc;
    else                        exp_pc = (mpc + 1) % PC_MOD;

    wait_fetch();
    chk("fetch_pc", pc, mpc);
    c      = {5'(op), 4'(rd), 8'(imm)};
    ivalid = 1'b1;
    flg    = f;
    @(negedge clk);
    ivalid = 1'b0;
    c      = IW'($urandom);
    chk("dec_ireq", ireq, 0);
    chk("dec_load", load, 0);
    chk("dec_cte", cte, imm);
    if (op < 16) chk("dec_sula_alu", sula, op);
    if (is_br)   chk("dec_sula_br", sula, 7);
    if (op < 16 || is_br) begin
      chk("dec_sba", sba, imm >> 4);
      chk("dec_sbb", sbb, imm & 15);
    end
    if (trap) begin
      @(negedge clk);
      chk("trap_halted", halted, 1);
      chk("trap_illegal", illegal, 1);
      chk("trap_pc", pc, mpc);
      chk("trap_load", load, 0);
      check_halted();
      do_reset(1'b0);
      return;
    end
    @(negedge clk);
    chk("exec_load", load, 0);
    chk("exec_cte", cte, imm);
    @(negedge clk);
    flg = ~f;
    chk("wb_load", load, is_load);
    chk("wb_cte", cte, imm);
    chk("wb_ireq", ireq, 0);
    chk("wb_illegal", illegal, 0);
    if (is_load) begin
      chk("wb_s", s, exp_s);
      chk("wb_srd", srd, rd);
    end
    if (is_br) chk("wb_sula_br", sula, 7);
    @(negedge clk);
    if (op == 31) begin
      chk("hlt_halted", halted, 1);
      chk("hlt_ireq", ireq, 0);
      chk("hlt_pc", pc, mpc);
      check_halted();
      do_reset(1'b0);
      return;
    end
    mpc = exp_pc;
    chk("next_pc", pc, mpc);
    chk("next_ireq", ireq, 1);
    chk("next_halted", halted, 0);
  endtask

  initial begin
    logic [PC_W-1:0]   pc0;
    logic [DATA_W-1:0] cte0;
    reset  = 1'b1;
    ivalid = 1'b0;
    c      = '0;
    flg    = '0;
    @(negedge clk);
    do_reset(1'b0);

    // LDI r3, 0x5A straight out of reset
    do_instr(16, 3, 'h5A, 6'b000000);
    do_instr(17, 9, 'h11, 6'b000000);
    // BZ taken, BZ not taken, branch to itself
    do_instr(18, 0, 'h40, 6'b100000);
    do_instr(18, 0, 'h77, 6'b000000);
    do_instr(18, 0, mpc, 6'b100000);
    do_instr(21, 2, 'h90, 6'b000100);
    // PC wrap from 0xFF
    do_instr(24, 0, 'hFF, 6'b000000);
    do_instr(1, 4, 'h12, 6'b000000);

    // FETCH stall with IVALID low
    wait_fetch();
    pc0  = pc;
    cte0 = cte;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ireq", ireq, 1);
      chk("stall_pc", pc, pc0);
      chk("stall_cte", cte, cte0);
      chk("stall_load", load, 0);
    end
    do_instr(2, 7, 'h33, 6'b000000);

    // 0x1A: trap or NOP depending on build
    do_instr(26, 1, 'h05, 6'b111111);
    do_instr(26, 1, 'h05, 6'b000000);

    // Reset during EXEC of an ALU op
    do_instr(24, 0, 'h20, 6'b000000);
    wait_fetch();
    c      = {5'd3, 4'd5, 8'h23};
    ivalid = 1'b1;
    @(negedge clk);
    ivalid = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // HALT, then reset concurrent with IVALID
    do_instr(31, 0, 'h00, 6'b000000);
    do_instr(5, 1, 'h10, 6'b000000);
    do_reset(1'b1);

    for (int n = 0; n < 200; n++) begin
      do_instr($urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 255),
               6'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end
endmodule
